bus_initiator: RTL and testbench

- Synchronous 68000-style asynchronous-bus initiator: drives AS/UDS/LDS/RW/address/data and completes cycles on DTACK or BERR.
- It is the master-side counterpart of the bus-control responder that decodes addresses and generates DTACK, chip selects and OE.
- Used as an FPGA-internal DMA/test bus master, and as a bench driver for the responder.
- Runs one word/byte transfer per request through a simple request/done command port.

---
 rtl/bus_initiator.sv | 175 +++++++++++++++++
 tb/tb_bus_initiator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// bus_initiator: 68000-style asynchronous-bus initiator.
// One word/byte transfer per REQ_IN. The cycle runs ADDR -> STRB -> (WDS) ->
// WAIT -> LATCH -> TERM and ends on DTACK_IN or BERR_IN.
// Optional macro BUS_INITIATOR_TIMEOUT_EN adds a WAIT-state watchdog.
// With the macro, WAIT ends with a bus error after TIMEOUT cycles.
module bus_initiator #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 24
) (
    input  logic              CPUCLK_IN,
    input  logic              RESET_IN,
    input  logic              REQ_IN,
    input  logic              WR_IN,
    input  logic [1:0]        BYTE_EN_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [15:0]       WDATA_IN,
    output logic [15:0]       RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] ADDR,
    output logic              AS,
    output logic              UDS,
    output logic              LDS,
    output logic              WR,
    output logic [15:0]       DATA_OUT,
    output logic              DATA_OE,
    input  logic [15:0]       DATA_IN,
    input  logic              DTACK_IN,
    input  logic              BERR_IN
);

    // The watchdog counter is 16 bits wide, so TIMEOUT must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_initiator: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STRB,
        S_WDS,
        S_WAIT,
        S_LATCH,
        S_TERM
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [15:0]         rdata_q, rdata_d;

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]         cnt_q, cnt_d;
`endif

    // State, latched request and read-data registers; async reset clears everything.
    always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            be_q    <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic: request acceptance, bus sequencing and completion.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
        // Zero outside WAIT, so the count restarts on every WAIT entry.
        cnt_d   = (state_q == S_WAIT) ? cnt_q + 16'd1 : 16'd0;
`endif
        case (state_q)
            S_IDLE: begin
                // A DTACK still high from the last slave holds off the next cycle.
                if (REQ_IN && !DTACK_IN) begin
                    wr_d    = WR_IN;
                    be_d    = BYTE_EN_IN;
                    addr_d  = ADDR_IN & ~ADDR_W'(1);
                    wdata_d = WDATA_IN;
                    if (BYTE_EN_IN == 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_TERM;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR:  state_d = S_STRB;
            S_STRB:  state_d = wr_q ? S_WDS : S_WAIT;
            S_WDS:   state_d = S_WAIT;
            S_WAIT: begin
                if (BERR_IN) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else if (DTACK_IN) begin
                    state_d = S_LATCH;
                end
`ifdef BUS_INITIATOR_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end
`endif
            end
            S_LATCH: begin
                if (!wr_q) rdata_d = DATA_IN;
                state_d = S_TERM;
            end
            S_TERM: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic active, strobe_on, ds_on, oe_on;

    // Bus and command-port outputs decoded from the current state.
    always_comb begin
        active    = (state_q != S_IDLE);
        strobe_on = (state_q == S_STRB) || (state_q == S_WDS) ||
                    (state_q == S_WAIT) || (state_q == S_LATCH);
        // Reads raise DS together with AS; writes raise it one cycle later, after data is on the bus.
        ds_on     = (state_q == S_WAIT) || (state_q == S_LATCH) ||
                    (state_q == S_WDS)  || (state_q == S_STRB && !wr_q);
        // Write data stays driven through TERM for hold time.
        // A byte-enable-00 request never drives the bus.
        oe_on     = wr_q && (be_q != 2'b00) &&
                    (strobe_on || state_q == S_TERM);

        BUSY     = active;
        DONE     = (state_q == S_TERM);
        ERR      = (state_q == S_TERM) && err_q;
        ADDR     = active ? addr_q : '0;
        WR       = active && wr_q;
        AS       = strobe_on;
        UDS      = ds_on && be_q[1];
        LDS      = ds_on && be_q[0];
        DATA_OE  = oe_on;
        DATA_OUT = oe_on ? wdata_q : 16'h0000;
        RDATA    = rdata_q;
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Testbench for bus_initiator.
// Directed transfer vectors, plus cycle-by-cycle sequences for the corner cases.
module tb_bus_initiator;

`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        REQ_IN, WR_IN;
    logic [1:0]  BYTE_EN_IN;
    logic [23:0] ADDR_IN;
    logic [15:0] WDATA_IN, DATA_IN;
    logic        DTACK_IN, BERR_IN;
    logic [15:0] RDATA, DATA_OUT;
    logic        BUSY, DONE, ERR, AS, UDS, LDS, WR, DATA_OE;
    logic [23:0] ADDR;

    int errors = 0;
    int checks = 0;

    bus_initiator #(.TIMEOUT(TMO), .ADDR_W(24)) dut (
        .CPUCLK_IN (clk),
        .RESET_IN  (rst),
        .REQ_IN    (REQ_IN),
        .WR_IN     (WR_IN),
        .BYTE_EN_IN(BYTE_EN_IN),
        .ADDR_IN   (ADDR_IN),
        .WDATA_IN  (WDATA_IN),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ADDR      (ADDR),
        .AS        (AS),
        .UDS       (UDS),
        .LDS       (LDS),
        .WR        (WR),
        .DATA_OUT  (DATA_OUT),
        .DATA_OE   (DATA_OE),
        .DATA_IN   (DATA_IN),
        .DTACK_IN  (DTACK_IN),
        .BERR_IN   (BERR_IN)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          wr;
        logic [1:0]  be;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        int          waits;
        bit          ack;
        bit          berr;
        int          exp_lat;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transfer; returns cycles from the accepting edge to DONE (-1 if none).
    task automatic run_vec(input vec_t v, output int lat, output logic err_o,
                           output logic [15:0] rd);
        int fw;
        fw = v.wr ? 4 : 3;
        WR_IN = v.wr; BYTE_EN_IN = v.be; ADDR_IN = v.addr; WDATA_IN = v.wdata;
        DATA_IN = v.din; DTACK_IN = 1'b0; BERR_IN = 1'b0; REQ_IN = 1'b1;
        tick();
        REQ_IN = 1'b0;
        lat = -1;
        err_o = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            DTACK_IN = v.ack  && (c >= fw + v.waits);
            BERR_IN  = v.berr && (c >= fw + v.waits);
            if (DONE) begin
                lat = c;
                err_o = ERR;
                break;
            end
            tick();
        end
        tick();
        DTACK_IN = 1'b0;
        BERR_IN  = 1'b0;
        rd = RDATA;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [15:0] rd;
        logic [5:0]  exp_bits [1:10];
        bit          done_seen;

        vecs.push_back('{"rd_be11",   1'b0, 2'b11, 24'h000100, 16'h0000, 16'hBEEF, 0, 1'b1, 1'b0, 5, 1'b0, 16'hBEEF});
        vecs.push_back('{"wr_be10",   1'b1, 2'b10, 24'h200002, 16'h1234, 16'h7777, 3, 1'b1, 1'b0, 9, 1'b0, 16'hBEEF});
        vecs.push_back('{"rd_berr",   1'b0, 2'b11, 24'h000040, 16'h0000, 16'h5555, 1, 1'b1, 1'b1, 5, 1'b1, 16'hBEEF});
        vecs.push_back('{"be00",      1'b0, 2'b00, 24'h000080, 16'h0000, 16'h1111, 0, 1'b1, 1'b0, 1, 1'b1, 16'hBEEF});
        vecs.push_back('{"rd_be01_w2",1'b0, 2'b01, 24'h000101, 16'h0000, 16'h00A5, 2, 1'b1, 1'b0, 7, 1'b0, 16'h00A5});
        vecs.push_back('{"wr_be01",   1'b1, 2'b01, 24'h000010, 16'hCAFE, 16'h2222, 0, 1'b1, 1'b0, 6, 1'b0, 16'h00A5});
        vecs.push_back('{"wr_berr",   1'b1, 2'b11, 24'h000020, 16'hAAAA, 16'h3333, 0, 1'b0, 1'b1, 5, 1'b1, 16'h00A5});
`ifdef BUS_INITIATOR_TIMEOUT_EN
        vecs.push_back('{"rd_tmo",    1'b0, 2'b11, 24'h000030, 16'h0000, 16'h4444, 0, 1'b0, 1'b0, 7, 1'b1, 16'h00A5});
`endif

        rst = 1'b1; REQ_IN = 1'b0; WR_IN = 1'b0; BYTE_EN_IN = 2'b00; ADDR_IN = '0;
        WDATA_IN = '0; DATA_IN = '0; DTACK_IN = 1'b0; BERR_IN = 1'b0;
        tick();
        tick();
        chk("reset_outs", {BUSY, DONE, ERR, AS, UDS, LDS, WR, DATA_OE},  8'h00);
        chk("reset_bus",  {ADDR, RDATA}, 40'h0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_vec(vecs[i], lat, e, rd);
            chk({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_err"},   e,   vecs[i].exp_err);
            chk({vecs[i].name, "_rdata"}, rd,  vecs[i].exp_rdata);
        end

        // Write with three wait states, cycle by cycle: {AS,UDS,LDS,OE,DONE,WR}.
        exp_bits[1] = 6'b000001;
        exp_bits[2] = 6'b100101;
        for (int c = 3; c <= 8; c++) exp_bits[c] = 6'b110101;
        exp_bits[9]  = 6'b000111;
        exp_bits[10] = 6'b000000;
        WR_IN = 1'b1; BYTE_EN_IN = 2'b10; ADDR_IN = 24'h200002; WDATA_IN = 16'h1234;
        REQ_IN = 1'b1;
        tick();
        REQ_IN = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            DTACK_IN = (c >= 7 && c <= 9);
            chk($sformatf("wr_seq_c%0d", c), {AS, UDS, LDS, DATA_OE, DONE, WR}, exp_bits[c]);
            if (c == 3) chk("wr_seq_data", DATA_OUT, 16'h1234);
            if (c == 9) chk("wr_seq_addr_term", ADDR, 24'h200002);
            if (c == 10) chk("wr_seq_addr_idle", ADDR, 24'h000000);
            tick();
        end
        DTACK_IN = 1'b0;

        // DTACK stuck high holds off a pending request.
        WR_IN = 1'b0; BYTE_EN_IN = 2'b11; ADDR_IN = 24'h000200; DATA_IN = 16'h0F0F;
        DTACK_IN = 1'b1; REQ_IN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stuck_idle%0d", c), {BUSY, AS}, 2'b00);
        end
        DTACK_IN = 1'b0;
        tick();
        chk("stuck_accept", BUSY, 1'b1);
        REQ_IN = 1'b0;
        DTACK_IN = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (DONE) begin
                lat = c;
                break;
            end
            tick();
        end
        chk("stuck_lat", lat, 5);
        tick();
        DTACK_IN = 1'b0;
        chk("stuck_rdata", RDATA, 16'h0F0F);

        // Reset pulsed in WAIT of a write: immediate drop, no DONE.
        WR_IN = 1'b1; BYTE_EN_IN = 2'b11; ADDR_IN = 24'h000300; WDATA_IN = 16'h5A5A;
        REQ_IN = 1'b1;
        tick();
        REQ_IN = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        chk("rst_pre_wait", {AS, UDS, LDS, DATA_OE, BUSY}, 5'b11111);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_drop", {AS, UDS, LDS, DATA_OE, BUSY, DONE, WR}, 7'b0);
        chk("rst_rdata", RDATA, 16'h0000);
        tick();
        rst = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (DONE || BUSY) done_seen = 1'b1;
            tick();
        end
        chk("rst_no_done", done_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
